// File: rtl/local_inject_ctrl_if.sv
// Core-to-injection-controller handshake: one flit plus its productive vector,
// transferred when coreValid and coreReady are both high at a rising clock edge.
interface local_inject_ctrl_if #(
    parameter int WIDTH_PORT = 64,
    parameter int WIDTH_PV   = 5
);
    logic [WIDTH_PORT-1:0] coreFlit;
    logic [WIDTH_PV-1:0]   corePV;
    logic                  coreValid;
    logic                  coreReady;

    modport master (
        output coreFlit,
        output corePV,
        output coreValid,
        input  coreReady
    );

    modport slave (
        input  coreFlit,
        input  corePV,
        input  coreValid,
        output coreReady
    );
endinterface

// File: rtl/local_inject_ctrl.sv
// Local-port injection controller: queues core flits and presents the head to the router,
// with throttling and starvation override. Define INJ_TIME_STAMP_EN to stamp TIME at enqueue.
module local_inject_ctrl #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_PV   = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_TH  = 8,
    localparam int WIDTH_PORT = 32 + WIDTH_DATA,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    local_inject_ctrl_if.slave    core,
    input  logic [3:0]            inVld,
    input  logic                  ejectVld,
    input  logic                  throttle,
    output logic [WIDTH_PORT-1:0] dinLocal,
    output logic [WIDTH_PV-1:0]   PVLocal,
    output logic                  starve,
    output logic [CNT_W-1:0]      fifoLevel
);

    typedef enum logic [1:0] {IDLE, PRESENT, HOLD, STARVED} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [7:0]       TH8     = 8'(STARVE_TH);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= TH8) ? TH8 : v + 8'd1;
    endfunction

    logic [WIDTH_PORT-1:0] mem_q [DEPTH];
    logic [WIDTH_PORT-1:0] mem_d [DEPTH];
    logic [WIDTH_PV-1:0]   pv_mem_q [DEPTH];
    logic [WIDTH_PV-1:0]   pv_mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      count_post_pop;
    logic [WIDTH_PORT-1:0] din_local_q, din_local_d;
    logic [WIDTH_PV-1:0]   pv_local_q, pv_local_d;
    logic                  starve_q, starve_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    state_t                state_q, state_d;
    logic [WIDTH_PORT-1:0] entry;
    logic                  core_ready;
    logic                  free_slot;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  load;
`ifdef INJ_TIME_STAMP_EN
    logic [7:0]            age_clk_q, age_clk_d;
`endif

    assign core_ready     = (count_q < DEPTH_C);
    assign core.coreReady = core_ready;

    always_comb begin
        free_slot = !(&inVld) | ejectVld;
        accept    = din_local_q[WIDTH_DATA] & free_slot;
        pop       = accept & (count_q != '0);
        push      = core.coreValid & core_ready;

        entry = core.coreFlit;
`ifdef INJ_TIME_STAMP_EN
        entry[WIDTH_DATA+7 +: 8] = age_clk_q;
        age_clk_d = age_clk_q + 8'd1;
`endif

        mem_d    = mem_q;
        pv_mem_d = pv_mem_q;
        if (push) begin
            mem_d[wr_ptr_q]    = entry;
            pv_mem_d[wr_ptr_q] = core.corePV;
        end

        wr_ptr_d       = wr_ptr_q + PTR_W'(push);
        rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        count_post_pop = count_q - CNT_W'(pop);

        // Reload reads the pre-edge array, so a same-edge push is never presented early.
        load        = (count_post_pop != '0) & (!throttle | starve_q);
        din_local_d = '0;
        pv_local_d  = '0;
        if (load) begin
            din_local_d             = mem_q[rd_ptr_d];
            din_local_d[WIDTH_DATA] = 1'b1;
            pv_local_d              = pv_mem_q[rd_ptr_d];
        end

        if (accept || count_q == '0)
            wait_cnt_d = 8'd0;
        else if (state_q != IDLE)
            wait_cnt_d = sat_inc(wait_cnt_q);
        else
            wait_cnt_d = wait_cnt_q;
        starve_d = (wait_cnt_d == TH8);

        if (count_d == '0)
            state_d = IDLE;
        else if (din_local_d[WIDTH_DATA])
            state_d = starve_d ? STARVED : PRESENT;
        else
            state_d = HOLD;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            din_local_q <= '0;
            pv_local_q  <= '0;
            starve_q    <= 1'b0;
            wait_cnt_q  <= 8'd0;
            state_q     <= IDLE;
`ifdef INJ_TIME_STAMP_EN
            age_clk_q   <= 8'd0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            din_local_q <= din_local_d;
            pv_local_q  <= pv_local_d;
            starve_q    <= starve_d;
            wait_cnt_q  <= wait_cnt_d;
            state_q     <= state_d;
`ifdef INJ_TIME_STAMP_EN
            age_clk_q   <= age_clk_d;
`endif
        end
    end

    // Storage needs no reset: count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        pv_mem_q <= pv_mem_d;
    end

    assign dinLocal  = din_local_q;
    assign PVLocal   = pv_local_q;
    assign starve    = starve_q;
    assign fifoLevel = count_q;

endmodule

// File: doc/local_inject_ctrl.md
Name: local_inject_ctrl

Overview:
Local-port injection controller for the bufferless deflection router (top_dec). It queues flits from the node core and presents the head flit on the router's dinLocal/PVLocal inputs. It holds that flit until the router has a free output slot, and throttles injection on network request. It raises a starvation flag when the head waits too long, and optionally stamps the link-format TIME field at enqueue.

Parameters:
WIDTH_DATA, 32, payload width; WIDTH_PORT = 32 + WIDTH_DATA
WIDTH_PV, 5, productive-vector width
DEPTH, 4, injection FIFO entries (power of 2, >= 2)
STARVE_TH, 8, consecutive blocked cycles before starve asserts (1..255)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
coreFlit  input  WIDTH_PORT  flit from core, link format [reqID 6|mshrID 5|pktSize 3|FLITID 3|TIME 8|POS_X 3|POS_Y 3|VLD 1|data]
corePV  input  WIDTH_PV  productive vector for coreFlit
coreValid  input  1  core offers a flit
coreReady  output  1  FIFO can accept; transfer when coreValid & coreReady at posedge
inVld  input  4  VLD bits of dinN, dinE, dinS, dinW this cycle
ejectVld  input  1  one inbound flit ejects to local this cycle
throttle  input  1  network throttle request
dinLocal  output  WIDTH_PORT  registered flit to router; VLD bit at [WIDTH_DATA]
PVLocal  output  WIDTH_PV  registered PV to router
starve  output  1  registered starvation flag
fifoLevel  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, dinLocal=0, PVLocal=0, starve=0, waitCnt=0, ageClk=0, state=IDLE, coreReady=1, fifoLevel=0.
- coreReady = (fifoLevel < DEPTH), combinational from the count register. A write is ignored when full.
- freeSlot = !(&inVld) | ejectVld.
- accept = dinLocal[WIDTH_DATA] & freeSlot, sampled at posedge. On accept the head is popped.
- The same-edge push and pop are both performed when nonempty. A push to a full FIFO with a simultaneous pop is still rejected, because coreReady=0.
- dinLocal/PVLocal are reloaded every posedge from the post-pop head:
  - if the FIFO is nonempty and (!throttle | starve), load head flit (VLD=1) and its PV;
  - otherwise load all zeros.
- Minimum latency: a push into an empty FIFO at edge k appears on dinLocal at edge k+1. A rejected flit stays presented unchanged.
- The FIFO is written and read at the same edge on empty. The pushed entry is visible to the reload at that edge only from edge k+1 (no fall-through).
- State machine, registered, evaluated on post-edge conditions:
  - IDLE: FIFO empty.
  - PRESENT: dinLocal valid.
  - HOLD: head present but throttled and !starve.
  - STARVED: starve=1 and dinLocal valid.
  - Transitions follow the conditions above. STARVED -> PRESENT/IDLE on accept.
- waitCnt (8-bit):
  - increments when state is PRESENT, HOLD or STARVED and there is no accept;
  - clears on accept or when the FIFO is empty;
  - saturates at STARVE_TH.
- starve = (waitCnt == STARVE_TH), registered. starve overrides throttle. It clears the cycle after accept.
- ageClk: 8-bit free-running counter, +1 per cycle, wraps 255->0.
- Reset mid-operation discards all queued flits. Outputs are zero at the next edge.

Optional Feature:
INJ_TIME_STAMP_EN
- Defined: at enqueue, the entry's TIME field (bits [WIDTH_DATA+14:WIDTH_DATA+7]) is overwritten with ageClk sampled at the write edge. This gives oldest-first priority a local injection age.
- Undefined: TIME passes unchanged from coreFlit, and ageClk is not instantiated.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> dinLocal=0, PVLocal=0, starve=0, fifoLevel=0, coreReady=1.
2. Single injection: push flit data 'hF, PV 5'b00010, with inVld=4'b0111 -> dinLocal VLD=1 one edge after the push. Popped at the next edge. dinLocal=0 afterwards and fifoLevel returns to 0.
3. Blocked slot: inVld=4'b1111, ejectVld=0 -> flit held unchanged. Then set ejectVld=1 for one cycle -> accepted, popped.
4. Starvation: throttle=1, one queued flit, STARVE_TH=8 -> dinLocal=0 (HOLD); starve=1 after 8 cycles; dinLocal valid next edge despite throttle; starve=0 after accept.
5. Full FIFO: push 5 flits back-to-back with inVld=4'b1111 -> 4 accepted, coreReady=0, 5th ignored. Drain order matches push order (data 'h1..'h4).
6. With INJ_TIME_STAMP_EN: push at ageClk=254 and at ageClk=0 (after wrap) -> TIME fields 8'd254 and 8'd0. Without the macro, TIME equals the core's value 8'd1.
